// File: rtl/m_uart_tx_pkg.sv
// m_uart_tx_pkg: definitions shared by the UART transmitter and its receiver counterpart.
//   - tx_state_e    : transmitter FSM state encoding (IDLE=0 .. PARITY=4)
//   - DEFAULT_TX_COUNT : one definition of the bit-period wait count, for both line ends
//   - FRAME_BITS    : bit periods per frame (10 for 8N1, 11 with UART_TX_PARITY_EN)
//   - frame_clocks(): clocks per frame for a given wait count
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit before stop).
package m_uart_tx_pkg;

  // Bit period is DEFAULT_TX_COUNT+1 clocks; the receiver's RX_COUNT must match.
  localparam int unsigned DEFAULT_TX_COUNT = 49;
  localparam int unsigned DATA_BITS        = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_BITS + 3;
`else
  localparam int unsigned FRAME_BITS = DATA_BITS + 2;
`endif

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } tx_state_e;

  function automatic int unsigned frame_clocks(input int unsigned tx_count);
    return FRAME_BITS * (tx_count + 1);
  endfunction

endpackage

// File: rtl/m_uart_tx_if.sv
// m_uart_tx_if: producer-side bundle of the UART transmitter.
//   w_din  : byte to send            (master -> slave)
//   w_we   : write strobe            (master -> slave)
//   w_full : FIFO full               (slave -> master)
//   w_busy : FIFO non-empty or frame in progress (slave -> master)
//   r_ovf  : sticky overflow flag    (slave -> master)
//   r_txd  : serial line, idle high  (slave -> master / board pin)
interface m_uart_tx_if;
  logic [7:0] w_din;
  logic       w_we;
  logic       w_full;
  logic       w_busy;
  logic       r_ovf;
  logic       r_txd;

  modport master (
    output w_din,
    output w_we,
    input  w_full,
    input  w_busy,
    input  r_ovf,
    input  r_txd
  );

  modport slave (
    input  w_din,
    input  w_we,
    output w_full,
    output w_busy,
    output r_ovf,
    output r_txd
  );
endinterface

// File: rtl/m_uart_tx_fifo.sv
// m_uart_tx_fifo: synchronous byte FIFO, async active-low reset.
//   clk_i, rst_ni : clock / reset
//   wr_i, din_i   : write request and data; ignored while full
//   rd_i, dout_o  : pop request; dout_o always shows the head entry
//   count_o       : occupancy 0..DEPTH
//   full_o/empty_o: derived from the registered count (pre-edge view)
module m_uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,  // power of two, >= 2
  parameter int unsigned DW    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       rd_i,
  output logic [DW-1:0]              dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wr_ok, rd_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle does not free a slot for this cycle's write.
  assign wr_ok = wr_i && !full_o;
  assign rd_ok = rd_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + {{PtrW{1'b0}}, wr_ok} - {{PtrW{1'b0}}, rd_ok};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/m_uart_tx.sv
// m_uart_tx: UART transmitter, 8N1, LSB first, with a small byte FIFO in front.
//   w_clk   : system clock
//   w_rst_x : asynchronous active-low reset (release synchronised by the parent)
//   tx_if   : m_uart_tx_if.slave -- w_din/w_we in; w_full, w_busy, r_ovf, r_txd out
// Bit period is TX_COUNT+1 clocks using the same wait-counter scheme as the receiver.
// Optional feature macro: UART_TX_PARITY_EN -- inserts an even-parity bit between the
// last data bit and stop (11 bit periods per frame instead of 10).
module m_uart_tx
  import m_uart_tx_pkg::*;
#(
  parameter int unsigned TX_COUNT   = DEFAULT_TX_COUNT,
  parameter int unsigned FIFO_DEPTH = 4,  // power of two, >= 2
  parameter int unsigned CNT_W      = 8   // must hold TX_COUNT
) (
  input  logic        w_clk,
  input  logic        w_rst_x,
  m_uart_tx_if.slave  tx_if
);

  localparam int unsigned FCntW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              tick;
  logic              pop;
  logic [7:0]        fifo_dout;
  logic [FCntW-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  m_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk_i   (w_clk),
    .rst_ni  (w_rst_x),
    .wr_i    (tx_if.w_we),
    .din_i   (tx_if.w_din),
    .rd_i    (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tick = (wait_q == CNT_W'(TX_COUNT));

  // Next-state: FSM, baud counter, shift register, sticky overflow.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    ovf_d   = ovf_q | (tx_if.w_we & fifo_full);
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Baud counter is parked at 0 in IDLE, so START always gets a full period.
    if (state_q == StIdle) begin
      wait_d = '0;
    end else if (tick) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (tick) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (tick) begin
          // Chain straight into the next START so back-to-back frames have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line level decoded from the current state and registered, so the pin is glitch-free
  // and follows the state one clock later (START entered at N+1 -> line low from N+2).
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = par_q;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_x) begin
    if (!w_rst_x) begin
      state_q <= StIdle;
      wait_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_if.w_full = fifo_full;
  assign tx_if.w_busy = (fifo_count != '0) || (state_q != StIdle);
  assign tx_if.r_ovf  = ovf_q;
  assign tx_if.r_txd  = txd_q;

endmodule

// File: doc/m_uart_tx.md
Name: m_uart_tx

Overview:
- UART transmitter, 8N1, LSB first; the transmit-side counterpart of the program-loader UART receiver.
- Bit timing uses the same wait-counter scheme as the receiver, so both ends agree at one clock frequency.
- Small byte FIFO decouples the producer (processor result dump / debug logic on the system clock) from line timing.
- Drives the board uart_txd pin, replacing the constant-1 tie-off.

Parameters:
TX_COUNT, 49, bit period = TX_COUNT+1 clocks; must match the receiver's RX_COUNT
FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2
CNT_W, 8, width of baud wait counter; must hold TX_COUNT

Ports:
w_clk  in  1  system clock
w_rst_x  in  1  reset, asynchronous, active-low
w_din  in  8  byte to send
w_we  in  1  write strobe; byte accepted on the clock edge if not full
w_full  out  1  FIFO holds FIFO_DEPTH bytes
w_busy  out  1  FIFO non-empty or frame in progress
r_ovf  out  1  sticky: a write was attempted while full
r_txd  out  1  serial line, idle high

Behaviour:
- Reset (async assert, sync-released by the parent): r_txd=1, FIFO empty, w_full=0, w_busy=0, r_ovf=0, state IDLE, wait counter 0, bit counter 0.
- Reset mid-frame aborts immediately: line returns high at once and FIFO contents are discarded.
- FIFO write: w_we && !w_full stores w_din at the write pointer and increments the count.
- w_we && w_full: data dropped and r_ovf<=1. r_ovf clears only on reset.
- w_full is computed from the count before the edge; a simultaneous pop does not free a slot for that same edge's write.
- FIFO pop occurs only on entry to START. Pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
- Baud counter r_wait: held at 0 in IDLE. Otherwise it counts 0..TX_COUNT and wraps to 0; "tick" = (r_wait==TX_COUNT).
- State machine:
  - IDLE: r_txd=1. If FIFO non-empty: pop the head into shift reg r_sh[7:0], go START, r_wait<=0.
  - START: r_txd=0 for TX_COUNT+1 clocks. On tick: go DATA, bit count 0.
  - DATA: r_txd=r_sh[0]. On tick: r_sh<=r_sh>>1 and bit count+1. After the tick with bit count==7, go STOP.
  - STOP: r_txd=1 for TX_COUNT+1 clocks. On tick: if FIFO non-empty, pop and go START directly (no idle gap); else go IDLE.
- r_txd is registered and changes only on state/bit transitions; no glitches.
- Latency: write into an empty FIFO while IDLE at edge N → count=1 after N. IDLE pops at N+1, so r_txd=0 from edge N+2.
- Frame length is 10*(TX_COUNT+1) clocks. Back-to-back frames contain no extra idle clocks.
- w_busy = (count!=0) || (state!=IDLE).

Optional Feature:
UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) is sent between the last data bit and stop, using a PARITY state of TX_COUNT+1 clocks. Frame becomes 11 bit periods. When undefined, there is no PARITY state and the frame is plain 8N1.

Decomposition:
- Shared package/header: state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4), frame-length constants, and the default TX_COUNT shared with the receiver side so both derive from one definition.
- Natural sub-module: m_uart_tx_fifo. It is a synchronous byte FIFO with async active-low reset and ports wr/din/rd/dout/count/full/empty; the FSM and baud logic stay in m_uart_tx.

Test Plan:
- TX_COUNT=3. Reset, write 0x55 once → starting 2 clocks after the write edge, r_txd shows 0,1,0,1,0,1,0,1,0,1, each held 4 clocks, 40 clocks total; then IDLE, w_busy=0.
- TX_COUNT=3. Write 0xA3 then 0x0F on consecutive cycles → two frames with no idle gap. Decode via a loopback m_UartRx at RX_COUNT=3 and check that r_en pulses with 0xA3 then 0x0F.
- FIFO_DEPTH=4, idle line. Write 6 bytes 0x01..0x06 in consecutive cycles:
  - The first byte is popped at the cycle after its write, so 0x01..0x05 are accepted; w_full=1 after the 5th write.
  - The 6th write is dropped and r_ovf=1.
  - The line carries 0x01..0x05 only.
- Write 0xFF, then deassert w_rst_x at the midpoint of data bit 3 → r_txd=1 immediately (asynchronous); after release w_busy=0, w_full=0, r_ovf=0 and no further frame is sent.
- Drive w_we while full and pop simultaneously (STOP tick with count=FIFO_DEPTH) → the write is dropped, r_ovf=1, and the count becomes FIFO_DEPTH-1.
- With UART_TX_PARITY_EN, send 0x07 → the parity bit is 1 and the frame is 44 clocks (TX_COUNT=3). Without the macro the frame is 40 clocks.
